// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer and its mediator bus access unit.
// Build option: define SPI_FLASH_FAST_READ_EN to issue 0x0B fast read with one dummy byte.
package spi_flash_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned REGA_W = 3;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned HCNT_W = 3;

  localparam logic [BYTE_W-1:0] OPC_READ      = 8'h03;
  localparam logic [BYTE_W-1:0] OPC_FAST_READ = 8'h0B;

  // Mediator register map
  localparam logic [REGA_W-1:0] REG_RXDATA   = 3'd0;
  localparam logic [REGA_W-1:0] REG_TXDATA   = 3'd1;
  localparam logic [REGA_W-1:0] REG_STATUS   = 3'd2;
  localparam logic [REGA_W-1:0] REG_CONTROL  = 3'd3;
  localparam logic [REGA_W-1:0] REG_SLAVESEL = 3'd5;

  localparam logic [REG_W-1:0] SS_MASK  = 16'h0001;
  localparam logic [REG_W-1:0] CTRL_SSO = 16'h0400;
  localparam logic [REG_W-1:0] CTRL_OFF = 16'h0000;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [BYTE_W-1:0] OPC_CMD = OPC_FAST_READ;
  localparam int unsigned       HDR_LEN = 5;
`else
  localparam logic [BYTE_W-1:0] OPC_CMD = OPC_READ;
  localparam int unsigned       HDR_LEN = 4;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_SS,
    ST_SSO_ON,
    ST_WAIT_TRDY,
    ST_WRITE,
    ST_WAIT_RRDY,
    ST_READ,
    ST_DELIVER,
    ST_SSO_OFF,
    ST_FINISH
  } seq_state_e;

  // Header byte by position; positions past addr[7:0] (dummy and data) are 0x00
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [HCNT_W-1:0] idx,
                                                 input logic [ADDR_W-1:0] a);
    logic [BYTE_W-1:0] b;
    case (idx)
      3'd0:    b = OPC_CMD;
      3'd1:    b = a[23:16];
      3'd2:    b = a[15:8];
      3'd3:    b = a[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_reg_access.sv
// Single mediator register access: two strobe cycles with stable address/data, then one idle cycle.
// Read data byte is captured on the edge that ends the second strobe cycle; ack pulses in the idle cycle.
module spi_reg_access
  import spi_flash_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [REGA_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              ack,
  output logic [BYTE_W-1:0] rdata,
  output logic [REGA_W-1:0] m_addr,
  output logic [REG_W-1:0]  m_wdata,
  output logic              m_read_n,
  output logic              m_write_n,
  output logic              m_select,
  input  logic [REG_W-1:0]  m_rdata
);

  typedef enum logic [1:0] {PH_IDLE, PH_STB1, PH_STB2, PH_GAP} phase_e;

  phase_e            phase_q, phase_d;
  logic              ack_q, ack_d;
  logic [BYTE_W-1:0] rdata_q, rdata_d;
  logic [REGA_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic              read_n_q, read_n_d;
  logic              write_n_q, write_n_d;
  logic              select_q, select_d;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = ^m_rdata[REG_W-1:BYTE_W];

  always_comb begin
    phase_d   = phase_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_n_d  = read_n_q;
    write_n_d = write_n_q;
    select_d  = select_q;
    case (phase_q)
      PH_IDLE: begin
        if (req) begin
          phase_d   = PH_STB1;
          select_d  = 1'b1;
          addr_d    = addr;
          wdata_d   = wdata;
          read_n_d  = we;
          write_n_d = !we;
        end
      end
      PH_STB1: phase_d = PH_STB2;
      PH_STB2: begin
        phase_d   = PH_GAP;
        ack_d     = 1'b1;
        select_d  = 1'b0;
        read_n_d  = 1'b1;
        write_n_d = 1'b1;
        if (!read_n_q) rdata_d = m_rdata[BYTE_W-1:0];
      end
      PH_GAP:  phase_d = PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_IDLE;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      select_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      select_q  <= select_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign m_read_n  = read_n_q;
  assign m_write_n = write_n_q;
  assign m_select  = select_q;

endmodule

// File: rtl/spi_flash_read_seq.sv
// SPI flash read command sequencer driving an SPI mediator through spi_reg_access.
// Define SPI_FLASH_FAST_READ_EN to use fast read (0x0B plus one dummy byte).
module spi_flash_read_seq
  import spi_flash_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [REGA_W-1:0] m_addr,
  output logic [REG_W-1:0]  m_wdata,
  output logic              m_read_n,
  output logic              m_write_n,
  output logic              m_select,
  input  logic [REG_W-1:0]  m_rdata,
  input  logic              m_dataavailable,
  input  logic              m_readyfordata
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HCNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]  data_cnt_q, data_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d;

  logic              acc_req_c, acc_we_c, acc_ack;
  logic [REGA_W-1:0] acc_addr_c;
  logic [REG_W-1:0]  acc_wdata_c;
  logic [BYTE_W-1:0] acc_rdata;

  // Register access request implied by the current state
  always_comb begin
    acc_req_c   = 1'b0;
    acc_we_c    = 1'b0;
    acc_addr_c  = '0;
    acc_wdata_c = '0;
    case (state_q)
      ST_SET_SS:  begin acc_req_c = 1'b1; acc_we_c = 1'b1; acc_addr_c = REG_SLAVESEL; acc_wdata_c = SS_MASK;  end
      ST_SSO_ON:  begin acc_req_c = 1'b1; acc_we_c = 1'b1; acc_addr_c = REG_CONTROL;  acc_wdata_c = CTRL_SSO; end
      ST_WRITE:   begin
        acc_req_c   = 1'b1;
        acc_we_c    = 1'b1;
        acc_addr_c  = REG_TXDATA;
        acc_wdata_c = {8'h00, hdr_byte(hdr_cnt_q, addr_q)};
      end
      ST_READ:    begin acc_req_c = 1'b1; acc_addr_c = REG_RXDATA; end
      ST_SSO_OFF: begin acc_req_c = 1'b1; acc_we_c = 1'b1; acc_addr_c = REG_CONTROL;  acc_wdata_c = CTRL_OFF; end
      default:    acc_req_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    hdr_cnt_d  = hdr_cnt_q;
    data_cnt_d = data_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SET_SS;
          busy_d     = 1'b1;
          addr_d     = addr;
          len_d      = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
          hdr_cnt_d  = '0;
          data_cnt_d = '0;
        end
      end
      ST_SET_SS:    if (acc_ack) state_d = ST_SSO_ON;
      ST_SSO_ON:    if (acc_ack) state_d = ST_WAIT_TRDY;
      ST_WAIT_TRDY: if (m_readyfordata) state_d = ST_WRITE;
      ST_WRITE:     if (acc_ack) state_d = ST_WAIT_RRDY;
      ST_WAIT_RRDY: if (m_dataavailable) state_d = ST_READ;
      ST_READ: begin
        if (acc_ack) begin
          // Bytes clocked in during opcode/address/dummy are dropped
          if (hdr_cnt_q < HCNT_W'(HDR_LEN)) begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            state_d   = ((hdr_cnt_q == HCNT_W'(HDR_LEN - 1)) && (len_q == '0)) ? ST_SSO_OFF
                                                                               : ST_WAIT_TRDY;
          end else begin
            rd_data_d  = acc_rdata;
            rd_valid_d = 1'b1;
            state_d    = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          data_cnt_d = data_cnt_q + 9'd1;
          state_d    = ((data_cnt_q + 9'd1) == len_q) ? ST_SSO_OFF : ST_WAIT_TRDY;
        end
      end
      ST_SSO_OFF: begin
        if (acc_ack) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      data_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      data_cnt_q <= data_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  spi_reg_access u_reg_access (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (acc_req_c),
    .we        (acc_we_c),
    .addr      (acc_addr_c),
    .wdata     (acc_wdata_c),
    .ack       (acc_ack),
    .rdata     (acc_rdata),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_read_n  (m_read_n),
    .m_write_n (m_write_n),
    .m_select  (m_select),
    .m_rdata   (m_rdata)
  );

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: behavioural SPI mediator, byte scoreboards and a command vector table.
// Follows SPI_FLASH_FAST_READ_EN for the expected header bytes.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] TB_OPC = 8'h0B;
  localparam int         TB_HDR = 5;
`else
  localparam logic [7:0] TB_OPC = 8'h03;
  localparam int         TB_HDR = 4;
`endif

  typedef struct {
    logic [23:0] addr;
    logic [8:0]  len;
    logic [7:0]  miso_base;
    bit          miso_inc;
    int          stall_byte;
    int          stall_cycles;
    bit          spur;
    int          exp_deliv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, rd_valid;
  logic        rd_ready = 1'b1;
  logic [7:0]  rd_data;
  logic [2:0]  m_addr;
  logic [15:0] m_wdata;
  logic        m_read_n, m_write_n, m_select;
  logic [15:0] m_rdata = '0;
  logic        m_dataavailable = 1'b0;
  logic        m_readyfordata = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [18:0] ctl_q[$];

  bit          pending, stalling, done_prev, miso_inc;
  int          rx_dly, rdy_dly, stb_run, tx_idx, tx_seen, delivered, done_cnt;
  int          exp_tx_cfg, exp_deliv_cfg, stall_byte, stall_left;
  logic [7:0]  miso_base, rx_val, stall_data;
  logic [2:0]  last_addr;
  logic [15:0] last_wdata;

  spi_flash_read_seq #(.MAX_LEN(256)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .addr            (addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .m_addr          (m_addr),
    .m_wdata         (m_wdata),
    .m_read_n        (m_read_n),
    .m_write_n       (m_write_n),
    .m_select        (m_select),
    .m_rdata         (m_rdata),
    .m_dataavailable (m_dataavailable),
    .m_readyfordata  (m_readyfordata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
    chk({tag, "_m_select"},  32'(m_select),  32'd0);
    chk({tag, "_m_read_n"},  32'(m_read_n),  32'd1);
    chk({tag, "_m_write_n"}, 32'(m_write_n), 32'd1);
    chk({tag, "_m_addr"},    32'(m_addr),    32'd0);
    chk({tag, "_m_wdata"},   32'(m_wdata),   32'd0);
  endtask

  // Mediator model, bus protocol monitor, rd stream consumer and done/busy checks
  always @(negedge clk) begin
    if (!reset_n) begin
      pending = 0; stalling = 0; done_prev = 0;
      rx_dly = 0; rdy_dly = 0; stb_run = 0;
      m_dataavailable = 1'b0; m_readyfordata = 1'b1; rd_ready = 1'b1;
    end else begin
      if (m_write_n && m_read_n) begin
        if (stb_run > 0) chk("strobe_len", 32'(stb_run), 32'd2);
        stb_run = 0;
      end else begin
        if (stb_run == 0) begin
          last_addr  = m_addr;
          last_wdata = m_wdata;
          chk("select_on_access", 32'(m_select), 32'd1);
          if (!m_write_n && m_addr == 3'd1) begin
            chk("tx_when_ready", 32'(m_readyfordata), 32'd1);
            chk("tx_one_outstanding", 32'(pending), 32'd0);
            chk("tx_during_stall", 32'(stalling), 32'd0);
            tx_seen++;
            if (tx_q.size() > 0) chk("tx_byte", 32'(m_wdata), 32'({8'h00, tx_q.pop_front()}));
            else chk("tx_count_overrun", 32'(tx_seen), 32'(exp_tx_cfg));
            rx_val = miso_inc ? 8'(miso_base + 8'(tx_idx)) : miso_base;
            tx_idx++;
            pending = 1; rx_dly = 3; m_readyfordata = 1'b0;
          end else if (!m_write_n) begin
            ctl_q.push_back({m_addr, m_wdata});
          end else begin
            chk("rx_reg_addr", 32'(m_addr), 32'd0);
            chk("rx_when_avail", 32'({pending, m_dataavailable}), 32'd3);
            pending = 0; m_dataavailable = 1'b0; rdy_dly = 2;
          end
        end else begin
          chk("bus_stable", 32'({m_select, m_addr, m_wdata}), 32'({1'b1, last_addr, last_wdata}));
        end
        stb_run++;
      end

      if (rx_dly > 0) begin
        rx_dly--;
        if (rx_dly == 0) begin m_dataavailable = 1'b1; m_rdata = {8'hEE, rx_val}; end
      end
      if (rdy_dly > 0) begin
        rdy_dly--;
        if (rdy_dly == 0) m_readyfordata = 1'b1;
      end

      rd_ready = 1'b1;
      if (stalling) begin
        chk("stall_valid", 32'(rd_valid), 32'd1);
        chk("stall_data", 32'(rd_data), 32'(stall_data));
        rd_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) stalling = 0;
      end else if (rd_valid && stall_left > 0 && delivered == stall_byte - 1) begin
        stalling = 1; stall_data = rd_data; rd_ready = 1'b0; stall_left--;
      end
      if (rd_valid && rd_ready) begin
        delivered++;
        if (exp_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        else chk("rd_count_overrun", 32'(delivered), 32'(exp_deliv_cfg));
      end

      if (done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 32'd1);
      end
      if (done_prev) chk("busy_after_done", 32'(busy), 32'd0);
      done_prev = done;
    end
  end

  task automatic prep(input vec_t v);
    tx_q.delete(); exp_q.delete(); ctl_q.delete();
    tx_q.push_back(TB_OPC);
    tx_q.push_back(v.addr[23:16]);
    tx_q.push_back(v.addr[15:8]);
    tx_q.push_back(v.addr[7:0]);
    if (TB_HDR == 5) tx_q.push_back(8'h00);
    for (int k = 0; k < v.exp_deliv; k++) begin
      tx_q.push_back(8'h00);
      exp_q.push_back(v.miso_inc ? 8'(v.miso_base + 8'(TB_HDR + k)) : v.miso_base);
    end
    miso_base = v.miso_base; miso_inc = v.miso_inc;
    tx_idx = 0; tx_seen = 0; delivered = 0; done_cnt = 0;
    exp_tx_cfg = TB_HDR + v.exp_deliv; exp_deliv_cfg = v.exp_deliv;
    stall_byte = v.stall_byte; stall_left = v.stall_cycles;
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    start = 1'b1; addr = v.addr; len = v.len;
    @(negedge clk);
    start = 1'b0; addr = 24'($urandom); len = 9'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    logic [18:0] exp_ctl [3];
    int cyc;
    exp_ctl[0] = {3'd5, 16'h0001};
    exp_ctl[1] = {3'd3, 16'h0400};
    exp_ctl[2] = {3'd3, 16'h0000};
    prep(v);
    launch(v);
    if (v.spur) begin
      repeat (12) @(negedge clk);
      chk("busy_before_spur", 32'(busy), 32'd1);
      start = 1'b1; addr = 24'hFFFFFF; len = 9'd7;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (40) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("tx_count", 32'(tx_seen), 32'(TB_HDR + v.exp_deliv));
    chk("deliv_count", 32'(delivered), 32'(v.exp_deliv));
    chk("tx_left", 32'(tx_q.size()), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("ctl_count", 32'(ctl_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < ctl_q.size(); i++) chk("ctl_write", 32'(ctl_q[i]), 32'(exp_ctl[i]));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   cyc;
    vecs[0] = '{24'h123456, 9'd4,   8'hA5, 1'b0, 0, 0,  1'b0, 4};
    vecs[1] = '{24'h000010, 9'd2,   8'h5C, 1'b1, 0, 0,  1'b0, 2};
    vecs[2] = '{24'h0ABCDE, 9'd0,   8'h77, 1'b0, 0, 0,  1'b0, 0};
    vecs[3] = '{24'h3C3C3C, 9'd3,   8'h10, 1'b1, 2, 50, 1'b0, 3};
    vecs[4] = '{24'h777777, 9'd5,   8'h81, 1'b1, 0, 0,  1'b1, 5};
    vecs[5] = '{24'hFEDCBA, 9'd1,   8'hC3, 1'b0, 0, 0,  1'b0, 1};
    vecs[6] = '{24'h000001, 9'd300, 8'h42, 1'b1, 0, 0,  1'b0, 256};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Abort during the second data byte, then a clean command
    rv = '{24'hABCDEF, 9'd4, 8'h30, 1'b1, 0, 0, 1'b0, 4};
    prep(rv);
    launch(rv);
    cyc = 0;
    while (delivered < 1 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("abort_point_reached", 32'(delivered), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    repeat (4) @(negedge clk);
    chk_reset("held_reset");
    chk("no_done_on_abort", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd('{24'h5A5A5A, 9'd3, 8'h60, 1'b1, 0, 0, 1'b0, 3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_flash_read_seq.md
SPI_FLASH_READ_SEQ -- requirements
Module: spi_flash_read_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, max data bytes per read command.
REQ-002 SHALL have ports `clk  in  1  system clock` and `reset_n  in  1  reset, asynchronous, active-low`.
REQ-003 SHALL have ports `start  in  1` (one-cycle request), `addr  in  24` (flash byte address), `len  in  9` (data byte count, 0..MAX_LEN).
REQ-004 SHALL have ports `busy  out  1`, `done  out  1` (one-cycle pulse at end of command).
REQ-005 SHALL have ports `rd_data  out  8`, `rd_valid  out  1`, `rd_ready  in  1` (received-byte stream).
REQ-006 SHALL have mediator master ports `m_addr  out  3`, `m_wdata  out  16`, `m_read_n  out  1`, `m_write_n  out  1`, `m_select  out  1`.
REQ-007 SHALL have mediator slave ports `m_rdata  in  16`, `m_dataavailable  in  1`, `m_readyfordata  in  1`.

Function
REQ-008 Every mediator access SHALL hold m_select=1, stable m_addr/m_wdata and one strobe low for exactly 2 cycles, then 1 idle cycle with both strobes high.
REQ-009 A read access SHALL capture m_rdata[7:0] at the end of its 2nd cycle.
REQ-010 start SHALL be accepted only in IDLE; start while busy SHALL be ignored; addr/len SHALL be latched on acceptance.
REQ-011 Sequence states: IDLE -> SET_SS (write reg5=0x0001) -> SSO_ON (write reg3=0x0400) -> loop {WAIT_TRDY -> WRITE (reg1) -> WAIT_RRDY -> READ (reg0) -> [DELIVER]} -> SSO_OFF (write reg3=0x0000) -> FINISH -> IDLE.
REQ-012 WAIT_TRDY SHALL leave only when m_readyfordata=1; WAIT_RRDY SHALL leave only when m_dataavailable=1.
REQ-013 Tx byte order SHALL be opcode, addr[23:16], addr[15:8], addr[7:0], then len bytes of 0x00; m_wdata[15:8]=0.
REQ-014 Rx bytes paired with opcode/address bytes SHALL be read and discarded; only rx bytes paired with data bytes SHALL enter DELIVER.
REQ-015 DELIVER SHALL assert rd_valid with rd_data stable until rd_valid&rd_ready; no further byte SHALL be written before the handshake.
REQ-016 Data byte counter SHALL be 9 bits; loop exits after the len-th delivered byte; len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-017 len=0 SHALL send opcode+address only, deliver nothing, then SSO_OFF and done.
REQ-018 busy SHALL be 1 from the cycle after start acceptance through the FINISH cycle; done SHALL pulse in FINISH.
REQ-019 Only one byte SHALL be outstanding in the mediator at any time (no write before the previous rx byte is read).

Reset
REQ-020 On reset_n low: state=IDLE, busy=0, done=0, rd_valid=0, rd_data=0, m_select=0, m_read_n=1, m_write_n=1, m_addr=0, m_wdata=0, counters=0.
REQ-021 Reset mid-command SHALL abandon the command with no done pulse; SSO release relies on the mediator sharing reset_n.

Configuration
REQ-022 With SPI_FLASH_FAST_READ_EN defined: opcode 0x0B, one 0x00 dummy byte after addr[7:0], its rx byte discarded.
REQ-023 Without SPI_FLASH_FAST_READ_EN: opcode 0x03, no dummy byte.

Structure
REQ-024 Shared package spi_flash_pkg SHALL hold the state enum, opcodes (0x03, 0x0B), mediator register indices (0,1,2,3,5) and the SSO/SS constants.
REQ-025 Sub-module spi_reg_access SHALL implement the REQ-008/009 bus cycle (req/we/addr/wdata in; ack/rdata out); the sequencer SHALL contain the FSM and counters.

Verification
REQ-026 start addr=0x123456 len=4, mediator model loops MISO=0xA5 -> MOSI bytes 03 12 34 56 00 00 00 00; 4×rd_data=0xA5; one done; reg3 written 0x0400 then 0x0000.
REQ-027 len=0 -> 4 tx bytes, rd_valid never 1, done pulses once, busy falls the cycle after done.
REQ-028 rd_ready held low 50 cycles on byte 2 of len=3 -> rd_valid/rd_data stable; no reg1 write during stall.
REQ-029 start pulsed again while busy -> ignored; only one command's bytes on MOSI.
REQ-030 reset_n low during byte 2 of data phase -> all outputs at reset values next cycle; no done; new start runs cleanly.
REQ-031 SPI_FLASH_FAST_READ_EN defined, addr=0x000010 len=2 -> MOSI 0B 00 00 10 00 00 00; exactly 2 bytes delivered.
